// File: rtl/jtframe_credits_hexprint.sv
// Writes NVAL 16-bit values as 4-digit uppercase hex into the credits overlay VRAM, or fills the page with spaces.
// Optional JTFRAME_CREDITS_HEXPRINT_HILITE_EN: items that changed since the previous print use the white palette.
module jtframe_credits_hexprint #(
  parameter int NVAL   = 8,
  parameter int ROW0   = 1,
  parameter int COL0   = 2,
  parameter int PERROW = 4
) (
  input  logic               rst,
  input  logic               clk,
  input  logic               cen,
  input  logic               start,
  input  logic               clear,
  input  logic [NVAL*16-1:0] values,
  output logic               busy,
  output logic               done,
  output logic [9:0]         vram_addr,
  output logic [7:0]         vram_dout,
  output logic               vram_we,
  output logic [1:0]         st_dbg
);

  // Handshake: start/clear are sampled on every clk edge; a write happens on
  // each clk where vram_we=1, with vram_addr/vram_dout valid in that same clk.
  typedef enum logic [1:0] {IDLE, CLEAR, WRITE, FINISH} state_t;

  localparam logic [9:0] BASE       = 10'((ROW0 * 32 + COL0) % 1024);
  localparam logic [4:0] LAST_ITEM  = 5'(NVAL - 1);
  localparam logic [4:0] LAST_FIELD = 5'(PERROW - 1);

  state_t             state, state_nx;
  logic               pend_start, pend_clear, op_write;
  logic [NVAL*16-1:0] snap;
  logic [9:0]         addr_q, line_base, field_base;
  logic [4:0]         item, field;
  logic [1:0]         pos;
  logic               enter_clear, enter_write, step;
  logic [15:0]        cur;
  logic [3:0]         nib;
  logic [6:0]         chr;
  logic               hl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    enter_clear = 1'b0;
    enter_write = 1'b0;
    step        = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    vram_we     = 1'b0;
    vram_dout   = 8'h00;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nx    = CLEAR;
          enter_clear = 1'b1;
        end else if (start) begin
          state_nx    = WRITE;
          enter_write = 1'b1;
        end
      end
      CLEAR: begin
        busy      = 1'b1;
        vram_we   = cen;
        vram_dout = 8'h20;
        step      = cen;
        if (cen && addr_q == 10'd1023) state_nx = FINISH;
      end
      WRITE: begin
        busy      = 1'b1;
        vram_we   = cen;
        vram_dout = {hl, chr};
        step      = cen;
        if (cen && item == LAST_ITEM && pos == 2'd3) state_nx = FINISH;
      end
      FINISH: begin
        done = 1'b1;
        // A pending clear is served before a pending print
        if (pend_clear || clear) begin
          state_nx    = CLEAR;
          enter_clear = 1'b1;
        end else if (pend_start || start) begin
          state_nx    = WRITE;
          enter_write = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign vram_addr = addr_q;
  assign st_dbg    = state;

  always_comb begin
    cur = 16'h0000;
    for (int k = 0; k < NVAL; k++)
      if (item == 5'(k)) cur = snap[16*k +: 16];
  end

  always_comb begin
    case (pos)
      2'd0:    nib = cur[15:12];
      2'd1:    nib = cur[11:8];
      2'd2:    nib = cur[7:4];
      default: nib = cur[3:0];
    endcase
    chr = (nib < 4'd10) ? (7'h30 + {3'b000, nib}) : (7'h37 + {3'b000, nib});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_start <= 1'b0;
      pend_clear <= 1'b0;
      op_write   <= 1'b0;
      snap       <= '0;
      addr_q     <= 10'd0;
      line_base  <= 10'd0;
      field_base <= 10'd0;
      item       <= 5'd0;
      field      <= 5'd0;
      pos        <= 2'd0;
    end else begin
      case (state)
        IDLE: if (clear && start) pend_start <= 1'b1;
        CLEAR, WRITE: begin
          if (start) pend_start <= 1'b1;
          if (clear) pend_clear <= 1'b1;
        end
        FINISH: begin
          if (pend_clear || clear) begin
            pend_clear <= 1'b0;
            pend_start <= pend_start | start;
          end else begin
            pend_start <= 1'b0;
          end
        end
        default: ;
      endcase
      if (enter_clear) begin
        op_write <= 1'b0;
        addr_q   <= 10'd0;
      end
      if (enter_write) begin
        op_write   <= 1'b1;
        snap       <= values;
        addr_q     <= BASE;
        line_base  <= BASE;
        field_base <= BASE;
        item       <= 5'd0;
        field      <= 5'd0;
        pos        <= 2'd0;
      end
      if (step) begin
        if (state == CLEAR) begin
          addr_q <= addr_q + 10'd1;
        end else if (pos != 2'd3) begin
          pos    <= pos + 2'd1;
          addr_q <= addr_q + 10'd1;
        end else begin
          // Last digit of a field: skip the separator or move to the next row
          pos  <= 2'd0;
          item <= item + 5'd1;
          if (field == LAST_FIELD) begin
            field      <= 5'd0;
            line_base  <= line_base + 10'd32;
            field_base <= line_base + 10'd32;
            addr_q     <= line_base + 10'd32;
          end else begin
            field      <= field + 5'd1;
            field_base <= field_base + 10'd5;
            addr_q     <= field_base + 10'd5;
          end
        end
      end
    end
  end

`ifdef JTFRAME_CREDITS_HEXPRINT_HILITE_EN
  logic [NVAL*16-1:0] prev;
  logic               force_all;
  logic [15:0]        prev_cur;

  always_comb begin
    prev_cur = 16'h0000;
    for (int k = 0; k < NVAL; k++)
      if (item == 5'(k)) prev_cur = prev[16*k +: 16];
  end

  assign hl = force_all | (cur != prev_cur);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev      <= '0;
      force_all <= 1'b1;
    end else begin
      if (state == FINISH && op_write) begin
        prev      <= snap;
        force_all <= 1'b0;
      end
      if (enter_clear) force_all <= 1'b1;
    end
  end
`else
  assign hl = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_credits_hexprint.sv
// Bench for jtframe_credits_hexprint: table vectors, hand sequences and randomized prints against a reference model.
module tb_jtframe_credits_hexprint;
  localparam int NVAL = 8, ROW0 = 1, COL0 = 2, PERROW = 4;
  localparam int WNVAL = 5, WROW0 = 31;
`ifdef JTFRAME_CREDITS_HEXPRINT_HILITE_EN
  localparam bit HILITE = 1'b1;
`else
  localparam bit HILITE = 1'b0;
`endif

  typedef struct {
    logic [15:0] val;
    logic [31:0] txt;
  } vec_t;

  logic clk = 1'b0;
  logic rst, cen, start, clear, w_start;
  logic [NVAL*16-1:0] values;
  logic [WNVAL*16-1:0] w_values;
  logic busy, done, vram_we, w_busy, w_done, w_we;
  logic [9:0] vram_addr, w_addr;
  logic [7:0] vram_dout, w_dout;
  logic [1:0] st_dbg, w_st;

  int vectors = 0, errors = 0;
  int cyc = 0, last_we_cyc = 0, done_cyc = 0, done_cnt = 0, prev_we = -1, busy_cnt = 0;
  bit pace = 1'b0;
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  logic [17:0] w_got_q[$];
  logic [15:0] prev_v[NVAL];
  bit force_all;

  jtframe_credits_hexprint #(.NVAL(NVAL), .ROW0(ROW0), .COL0(COL0), .PERROW(PERROW)) u_dut (
    .rst(rst), .clk(clk), .cen(cen), .start(start), .clear(clear), .values(values),
    .busy(busy), .done(done), .vram_addr(vram_addr), .vram_dout(vram_dout),
    .vram_we(vram_we), .st_dbg(st_dbg)
  );

  jtframe_credits_hexprint #(.NVAL(WNVAL), .ROW0(WROW0), .COL0(COL0), .PERROW(PERROW)) u_wrap (
    .rst(rst), .clk(clk), .cen(cen), .start(w_start), .clear(1'b0), .values(w_values),
    .busy(w_busy), .done(w_done), .vram_addr(w_addr), .vram_dout(w_dout),
    .vram_we(w_we), .st_dbg(w_st)
  );

  // clock / reset / pacing
  always #5 clk = ~clk;

  initial begin
    int ph = 0;
    cen = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph  = (ph + 1) % 4;
      cen = pace ? (ph == 0) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // write monitor
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_we = -1;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        prev_we  = -1;
      end
      if (vram_we) begin
        check("we only on cen", 32'(cen), 32'd1);
        got_q.push_back({vram_addr, vram_dout});
        last_we_cyc = cyc;
        if (pace && prev_we >= 0) check("pacing gap", 32'(cyc - prev_we), 32'd4);
        prev_we = cyc;
      end
      if (w_we) w_got_q.push_back({w_addr, w_dout});
    end
  end

  // reference model
  function automatic logic [6:0] hex_char(input int n);
    return (n < 10) ? 7'(48 + n) : 7'(65 + n - 10);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NVAL; i++) prev_v[i] = 16'h0000;
    force_all = 1'b1;
  endtask

  task automatic model_clear();
    for (int a = 0; a < 1024; a++) exp_q.push_back({10'(a), 8'h20});
    force_all = 1'b1;
  endtask

  task automatic model_print(input logic [NVAL*16-1:0] vals);
    logic [15:0] v;
    int a, n;
    bit chg;
    for (int i = 0; i < NVAL; i++) begin
      v   = vals[16*i +: 16];
      chg = HILITE && (force_all || v != prev_v[i]);
      for (int k = 0; k < 4; k++) begin
        n = int'((v >> (12 - 4 * k)) & 16'hf);
        a = ((ROW0 + i / PERROW) * 32 + COL0 + (i % PERROW) * 5 + k) % 1024;
        exp_q.push_back({10'(a), chg, hex_char(n)});
      end
    end
    for (int i = 0; i < NVAL; i++) prev_v[i] = vals[16*i +: 16];
    force_all = 1'b0;
  endtask

  function automatic logic [NVAL*16-1:0] rand_vals();
    logic [NVAL*16-1:0] r;
    for (int i = 0; i < NVAL; i++) r[16*i +: 16] = 16'($urandom);
    return r;
  endfunction

  // driver tasks
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n >= budget) begin
      vectors++;
      errors++;
      $display("FAIL %s: no done within %0d clks", name, budget);
    end
  endtask

  task automatic check_writes(input string name);
    logic [17:0] g, e;
    check({name, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check(name, 32'(g), 32'(e));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t tbl[6];
    logic [9:0] ea[8];
    logic [7:0] ed[8];
    logic [NVAL*16-1:0] v2;
    int cnt, d0;

    tbl[0] = '{16'h0000, "0000"};
    tbl[1] = '{16'hFFFF, "FFFF"};
    tbl[2] = '{16'h9A5F, "9A5F"};
    tbl[3] = '{16'h789C, "789C"};
    tbl[4] = '{16'hBEEF, "BEEF"};
    tbl[5] = '{16'h0A09, "0A09"};
    ea = '{10'd34, 10'd35, 10'd36, 10'd37, 10'd39, 10'd40, 10'd41, 10'd42};
    ed = '{8'h31, 8'h32, 8'h41, 8'h42, 8'h46, 8'h30, 8'h30, 8'h44};

    rst = 1'b1; start = 1'b0; clear = 1'b0; w_start = 1'b0;
    values = '0; w_values = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset we", 32'(vram_we), 0);
    check("reset addr", 32'(vram_addr), 0);
    check("reset dout", 32'(vram_dout), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // full clear
    busy_cnt = 0; done_cnt = 0;
    model_clear();
    pulse_clear();
    wait_done("clear done", 1200);
    @(negedge clk); #1;
    check("clear busy clks", 32'(busy_cnt), 32'd1024);
    check("clear done after last write", 32'(done_cyc), 32'(last_we_cyc + 1));
    check("clear done pulses", 32'(done_cnt), 32'd1);
    check_writes("clear write");

    // known print: item0=12AB, item1=F00D
    values = rand_vals();
    values[31:0] = {16'hF00D, 16'h12AB};
    model_print(values);
    pulse_start();
    wait_done("print done", 200);
    check("print write total", 32'(got_q.size()), 32'(NVAL * 4));
    if (got_q.size() >= 20) begin
      for (int j = 0; j < 8; j++) begin
        check("fixed addr", 32'(got_q[j][17:8]), 32'(ea[j]));
        check("fixed char", 32'(got_q[j][6:0]), 32'(ed[j][6:0]));
      end
      for (int j = 0; j < 4; j++) check("row wrap addr", 32'(got_q[16+j][17:8]), 32'(66 + j));
    end
    cnt = 0;
    foreach (got_q[j]) if (got_q[j][17:8] == 10'd38) cnt++;
    check("separator untouched", 32'(cnt), 0);
    check_writes("print write");

    // table-driven digit mapping on item 0
    for (int t = 0; t < 6; t++) begin
      values = rand_vals();
      values[15:0] = tbl[t].val;
      model_print(values);
      pulse_start();
      wait_done("table done", 200);
      if (got_q.size() >= 4)
        for (int j = 0; j < 4; j++)
          check("table char", 32'(got_q[j][6:0]), 32'((tbl[t].txt >> (24 - 8 * j)) & 32'h7f));
      check_writes("table write");
    end

    // paced prints, one cen in four
    pace = 1'b1;
    for (int t = 0; t < 3; t++) begin
      values = rand_vals();
      model_print(values);
      pulse_start();
      wait_done("paced done", 400);
      check_writes("paced write");
    end
    pace = 1'b0;
    repeat (4) @(posedge clk);

    // start and clear in the same clk
    d0 = done_cnt;
    values = rand_vals();
    model_clear();
    model_print(values);
    @(posedge clk); #1 start = 1'b1; clear = 1'b1;
    @(posedge clk); #1 start = 1'b0; clear = 1'b0;
    wait_done("overlap done 1", 1200);
    wait_done("overlap done 2", 200);
    repeat (40) @(negedge clk);
    check("overlap done pulses", 32'(done_cnt - d0), 32'd2);
    check_writes("overlap write");

    // two starts during a print merge into one extra print with a fresh snapshot
    d0 = done_cnt;
    values = rand_vals();
    v2 = rand_vals();
    model_print(values);
    model_print(v2);
    pulse_start();
    repeat (4) @(posedge clk);
    #2 values = v2;
    pulse_start();
    repeat (2) @(posedge clk);
    pulse_start();
    wait_done("pend done 1", 200);
    wait_done("pend done 2", 200);
    repeat (60) @(negedge clk);
    check("pend done pulses", 32'(done_cnt - d0), 32'd2);
    check_writes("pend write");

    // palette: same value twice, then a change
    foreach (tbl[t]) begin
      values = rand_vals();
      values[15:0] = (t < 2) ? 16'h1234 : 16'h1235;
      if (t > 0) values = {values[NVAL*16-1:16], 16'h0000} | {{(NVAL-1)*16{1'b0}}, values[15:0]};
      if (t < 3) begin
        for (int i = 1; i < NVAL; i++) values[16*i +: 16] = prev_v[i];
        model_print(values);
        pulse_start();
        wait_done("hilite done", 200);
        check_writes("hilite write");
      end
    end

    // randomized prints and clears
    for (int t = 0; t < 6; t++) begin
      pace = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 4) == 0) begin
        model_clear();
        pulse_clear();
        wait_done("rand clear done", 5000);
      end else begin
        values = rand_vals();
        model_print(values);
        pulse_start();
        wait_done("rand print done", 400);
      end
      check_writes("rand write");
    end
    pace = 1'b0;

    // reset in the middle of a print
    values = rand_vals();
    pulse_start();
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midreset busy", 32'(busy), 0);
    check("midreset we", 32'(vram_we), 0);
    check("midreset addr", 32'(vram_addr), 0);
    check("midreset dout", 32'(vram_dout), 0);
    d0 = done_cnt;
    @(posedge clk); #1 rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    check("midreset no done", 32'(done_cnt - d0), 0);
    values = rand_vals();
    model_print(values);
    pulse_start();
    wait_done("after reset done", 200);
    check_writes("after reset write");

    // 10-bit address wrap on the second instance
    for (int i = 0; i < WNVAL; i++) w_values[16*i +: 16] = 16'($urandom);
    w_got_q.delete();
    @(posedge clk); #1 w_start = 1'b1;
    @(posedge clk); #1 w_start = 1'b0;
    cnt = 0;
    while (cnt < 200 && !w_done) begin
      @(negedge clk);
      cnt++;
    end
    check("wrap finished", 32'(w_done), 32'd1);
    check("wrap write total", 32'(w_got_q.size()), 32'(WNVAL * 4));
    if (w_got_q.size() >= 20) begin
      check("wrap item0 addr", 32'(w_got_q[0][17:8]), 32'd994);
      for (int j = 0; j < 4; j++) begin
        check("wrap item4 addr", 32'(w_got_q[16+j][17:8]), 32'(2 + j));
        check("wrap item4 char", 32'(w_got_q[16+j][6:0]),
              32'(hex_char(int'((w_values[64 +: 16] >> (12 - 4 * j)) & 16'hf))));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/jtframe_credits_hexprint.md
Name: jtframe_credits_hexprint

Overview:
- Text writer placed directly upstream of the credits overlay. It drives the overlay's optional VRAM write port (10-bit address, 8-bit data, write enable).
- On request, it prints a set of 16-bit status/debug values as 4-digit uppercase ASCII hex at fixed screen positions.
- On a separate request, it clears the 32x32 character page to spaces.
- Data bit 7 selects the overlay's palette 2 (blue) or palette 3 (white).

Parameters:
- NVAL, 8: number of 16-bit values printed (1..32).
- ROW0, 1: first character row (0..31).
- COL0, 2: first character column (0..31).
- PERROW, 4: fields per row. A field is 4 digits plus 1 untouched separator column, so the field stride is 5.

Ports:
- rst  in  1  reset.
- clk  in  1  clock.
- cen  in  1  write pacing enable; at most one VRAM write per clk with cen=1.
- start  in  1  level-sampled print request.
- clear  in  1  level-sampled clear request.
- values  in  NVAL*16  packed values; item i is values[16*i+15:16*i].
- busy  out  1  high while in CLEAR or WRITE.
- done  out  1  one-clk pulse when an operation finishes.
- vram_addr  out  10  character address, computed as row*32+col.
- vram_dout  out  8  {palette bit, 7-bit character code}.
- vram_we  out  1  write strobe; high for exactly one clk per write.

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. On reset: busy=0, done=0, vram_we=0, vram_addr=0, vram_dout=0, state IDLE, pending flags cleared, snapshot cleared.
- States: IDLE, CLEAR, WRITE, FINISH.
- IDLE:
  - clear=1: go to CLEAR. If start=1 at the same time, set pend_start.
  - else start=1: capture values into the snapshot, then go to WRITE.
  - busy rises on the edge that leaves IDLE.
- CLEAR:
  - On each clk with cen=1: vram_we=1, vram_dout=8'h20, address steps 0..1023.
  - After the write to 1023, go to FINISH.
  - Exactly 1024 writes.
- WRITE:
  - For item i=0..NVAL-1, digit d=3..0 (MSB first): one write per cen clk.
  - Address = (ROW0 + i/PERROW)*32 + COL0 + (i%PERROW)*5 + (3-d), kept mod 1024 (10-bit wrap, no error).
  - Implement with incremental row/column counters; no dividers.
  - Character: nibble 0-9 maps to 8'h30+n; nibble A-F maps to 8'h41+(n-10). Bit 7 is 0.
  - Separator columns are never written.
  - After NVAL*4 writes, go to FINISH.
- FINISH:
  - done=1 and busy=0 for one clk.
  - If pend_start is set: clear it and re-enter WRITE on the next clk with a fresh snapshot. Otherwise go to IDLE.
- Requests during busy:
  - start is latched into pend_start (one deep).
  - clear is latched into pend_clear. It is served before pend_start at FINISH, via FINISH→CLEAR.
  - Further requests while a flag is set are merged into that flag.
- cen=0: state, counters and outputs hold; vram_we=0.
- Timing: vram_addr and vram_dout are valid in the same clk as vram_we. The first write occurs on the first cen clk after entering CLEAR or WRITE.
- Snapshot: values are sampled only at WRITE entry, so changes during a print do not tear the digits.
- Reset mid-operation: aborts immediately to reset values; no partial-completion done.

Optional Feature:
- Macro: JTFRAME_CREDITS_HEXPRINT_HILITE_EN.
- Defined:
  - A second register bank holds the previous snapshot.
  - All 4 digits of any item whose value differs from the previous print are written with vram_dout[7]=1 (white palette). Unchanged items use bit 7=0.
  - The previous bank updates at FINISH of each WRITE.
  - Reset and CLEAR set every item to "changed", so the first print after either is all white.
- Undefined: bit 7 is always 0; no extra bank.

Test Plan:
- Clear, cen=1: pulse clear → 1024 writes, addr 0..1023, data 8'h20; done pulse one clk after the write to 1023; busy high for 1024 clks.
- Print, NVAL=2, ROW0=1, COL0=2, values {16'hF00D, 16'h12AB}:
  - writes addr 34..37 = 31,32,41,42;
  - then addr 39..42 = 46,30,30,44;
  - addr 38 untouched; 8 writes total.
- Row wrap, NVAL=5, PERROW=4: item 4 is written at addr 66..69; ROW0=31 places it at addr 2..5 (10-bit wrap).
- Pacing: cen high one clk in four during print → vram_we pulses exactly 4 clks apart; no write on cen=0 clks.
- Overlap: start and clear in the same clk → full clear, then full print; two done pulses. start during print → exactly one extra print.
- With HILITE: print 16'h1234 twice, then 16'h1235 → first print bit7=1, second bit7=0, third bit7=1.
- Reset asserted mid-print: outputs zero at once; next start prints from item 0.
